// File: rtl/inst_data_mem_arbiter_pkg.sv
// rtl/inst_data_mem_arbiter_pkg.sv - shared constants and state encoding for the IF/MEM RAM arbiter
package inst_data_mem_arbiter_pkg;

   localparam logic RST_ENABLE = 1'b1;

   localparam logic ARB_IF  = 1'b0;
   localparam logic ARB_MEM = 1'b1;

   // Wide enough for RD_LATENCY and MAX_DATA_RUN up to 15
   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_ACCESS = 2'd1,
      ARB_WAIT   = 2'd2,
      ARB_DONE   = 2'd3
   } arb_state_t;

endpackage

// File: rtl/inst_data_mem_arb_pick.sv
// rtl/inst_data_mem_arb_pick.sv - fixed MEM priority with a run cap that guarantees IF progress
module inst_data_mem_arb_pick
   import inst_data_mem_arbiter_pkg::*;
#(
   parameter int MAX_DATA_RUN = 4
) (
   input  logic             if_req,
   input  logic             d_req,
   input  logic [CNT_W-1:0] run,
   output logic             grant_valid,
   output logic             grant_id,
   output logic [CNT_W-1:0] run_next
);

   localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(MAX_DATA_RUN);

   always_comb begin
      grant_valid = if_req | d_req;
      grant_id    = ARB_IF;
      run_next    = '0;
      if (d_req && !(if_req && run == RUN_MAX)) begin
         grant_id = ARB_MEM;
         // MEM only wins over a waiting IF below the cap, so this never exceeds RUN_MAX
         if (if_req) begin
            run_next = run + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/inst_data_mem_arbiter.sv
// rtl/inst_data_mem_arbiter.sv - shares one synchronous RAM between instruction fetch and load/store
module inst_data_mem_arbiter
   import inst_data_mem_arbiter_pkg::*;
#(
   parameter int RD_LATENCY   = 1,
   parameter int MAX_DATA_RUN = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_ack,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [3:0]  d_sel,
   input  logic [31:0] d_wdata,
   output logic        d_ack,
   output logic [31:0] d_rdata,
   output logic        ram_ce,
   output logic        ram_we,
   output logic [31:0] ram_addr,
   output logic [3:0]  ram_sel,
   output logic [31:0] ram_wdata,
   input  logic [31:0] ram_rdata,
   output logic        stallreq_if,
   output logic        stallreq_mem
);

   arb_state_t       state, state_nxt;
   logic [CNT_W-1:0] run, run_nxt, run_pick;
   logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
   logic             win_id, win_id_nxt;
   logic             win_we, win_we_nxt;
   logic             grant_valid, grant_id;
   logic             last_wait;
   logic             ram_ce_nxt, ram_we_nxt;
   logic [31:0]      ram_addr_nxt, ram_wdata_nxt;
   logic [3:0]       ram_sel_nxt;
   logic             if_ack_nxt, d_ack_nxt;
   logic [31:0]      if_rdata_nxt, d_rdata_nxt;

   inst_data_mem_arb_pick #(
      .MAX_DATA_RUN(MAX_DATA_RUN)
   ) u_pick (
      .if_req     (if_req),
      .d_req      (d_req),
      .run        (run),
      .grant_valid(grant_valid),
      .grant_id   (grant_id),
      .run_next   (run_pick)
   );

   assign last_wait    = (wait_cnt == CNT_W'(1));
   assign stallreq_if  = if_req & ~if_ack;
   assign stallreq_mem = d_req & ~d_ack;

   always_ff @(posedge clk or posedge rst) begin
      if (rst == RST_ENABLE) begin
         state <= ARB_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ARB_IDLE:   if (grant_valid) state_nxt = ARB_ACCESS;
         ARB_ACCESS: state_nxt = win_we ? ARB_DONE : ARB_WAIT;
         ARB_WAIT:   if (last_wait) state_nxt = ARB_DONE;
         ARB_DONE:   state_nxt = ARB_IDLE;
         default:    state_nxt = ARB_IDLE;
      endcase
   end

   always_comb begin
      run_nxt       = run;
      win_id_nxt    = win_id;
      win_we_nxt    = win_we;
      wait_cnt_nxt  = wait_cnt;
      ram_ce_nxt    = 1'b0;
      ram_we_nxt    = 1'b0;
      ram_addr_nxt  = ram_addr;
      ram_sel_nxt   = ram_sel;
      ram_wdata_nxt = ram_wdata;
      if_ack_nxt    = 1'b0;
      d_ack_nxt     = 1'b0;
      if_rdata_nxt  = if_rdata;
      d_rdata_nxt   = d_rdata;
      case (state)
         ARB_IDLE: begin
            if (grant_valid) begin
               run_nxt    = run_pick;
               win_id_nxt = grant_id;
               ram_ce_nxt = 1'b1;
               if (grant_id == ARB_MEM) begin
                  win_we_nxt    = d_we;
                  ram_we_nxt    = d_we;
                  ram_addr_nxt  = d_addr;
                  ram_sel_nxt   = d_sel;
                  ram_wdata_nxt = d_wdata;
               end else begin
                  win_we_nxt    = 1'b0;
                  ram_addr_nxt  = if_addr;
                  ram_sel_nxt   = 4'hF;
                  ram_wdata_nxt = '0;
               end
            end
         end
         ARB_ACCESS: begin
            // only MEM grants can carry a write
            if (win_we) begin
               d_ack_nxt = 1'b1;
            end else begin
               wait_cnt_nxt = CNT_W'(RD_LATENCY);
            end
         end
         ARB_WAIT: begin
            wait_cnt_nxt = wait_cnt - CNT_W'(1);
            if (last_wait) begin
               if (win_id == ARB_MEM) begin
                  d_rdata_nxt = ram_rdata;
                  d_ack_nxt   = 1'b1;
               end else begin
                  if_rdata_nxt = ram_rdata;
                  if_ack_nxt   = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst == RST_ENABLE) begin
         run       <= '0;
         win_id    <= ARB_IF;
         win_we    <= 1'b0;
         wait_cnt  <= '0;
         ram_ce    <= 1'b0;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_sel   <= '0;
         ram_wdata <= '0;
         if_ack    <= 1'b0;
         d_ack     <= 1'b0;
         if_rdata  <= '0;
         d_rdata   <= '0;
      end else begin
         run       <= run_nxt;
         win_id    <= win_id_nxt;
         win_we    <= win_we_nxt;
         wait_cnt  <= wait_cnt_nxt;
         ram_ce    <= ram_ce_nxt;
         ram_we    <= ram_we_nxt;
         ram_addr  <= ram_addr_nxt;
         ram_sel   <= ram_sel_nxt;
         ram_wdata <= ram_wdata_nxt;
         if_ack    <= if_ack_nxt;
         d_ack     <= d_ack_nxt;
         if_rdata  <= if_rdata_nxt;
         d_rdata   <= d_rdata_nxt;
      end
   end

endmodule

// File: tb/tb_inst_data_mem_arbiter.sv
// tb/tb_inst_data_mem_arbiter.sv - randomized bench for the IF/MEM RAM arbiter against a cycle-budget model
module tb_inst_data_mem_arbiter;

   localparam int RD_LATENCY   = 3;
   localparam int MAX_DATA_RUN = 4;

   typedef struct {
      int          gap;
      logic        we;
      logic [31:0] addr;
      logic [3:0]  sel;
      logic [31:0] wdata;
   } req_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        if_req, d_req, d_we;
   logic [31:0] if_addr, d_addr, d_wdata;
   logic [3:0]  d_sel;
   logic        if_ack, d_ack;
   logic [31:0] if_rdata, d_rdata;
   logic        ram_ce, ram_we;
   logic [31:0] ram_addr, ram_wdata, ram_rdata;
   logic [3:0]  ram_sel;
   logic        stallreq_if, stallreq_mem;
   logic        ram_load = 1'b1;

   inst_data_mem_arbiter #(
      .RD_LATENCY  (RD_LATENCY),
      .MAX_DATA_RUN(MAX_DATA_RUN)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .if_req      (if_req),
      .if_addr     (if_addr),
      .if_ack      (if_ack),
      .if_rdata    (if_rdata),
      .d_req       (d_req),
      .d_we        (d_we),
      .d_addr      (d_addr),
      .d_sel       (d_sel),
      .d_wdata     (d_wdata),
      .d_ack       (d_ack),
      .d_rdata     (d_rdata),
      .ram_ce      (ram_ce),
      .ram_we      (ram_we),
      .ram_addr    (ram_addr),
      .ram_sel     (ram_sel),
      .ram_wdata   (ram_wdata),
      .ram_rdata   (ram_rdata),
      .stallreq_if (stallreq_if),
      .stallreq_mem(stallreq_mem)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] seed_word(input int i);
      if (i == 4) return 32'h3401_1100;
      return 32'h1357_9BDF ^ (i * 32'h0101_0101);
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] sel);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   // Synchronous RAM with RD_LATENCY-deep read pipe; stale slots carry a junk marker
   logic [31:0] ram_mem [64];
   logic [31:0] rd_pipe [RD_LATENCY];
   always @(posedge clk) begin
      if (ram_load) begin
         for (int i = 0; i < 64; i++) ram_mem[i] <= seed_word(i);
      end else if (ram_ce && ram_we) begin
         ram_mem[ram_addr[7:2]] <= merge(ram_mem[ram_addr[7:2]], ram_wdata, ram_sel);
      end
      rd_pipe[0] <= (ram_ce && !ram_we) ? ram_mem[ram_addr[7:2]] : 32'hBAAD_F00D;
      for (int i = 1; i < RD_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign ram_rdata = rd_pipe[RD_LATENCY-1];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Reference model: transaction-level budget of when the shared RAM is next free
   req_t        if_q[$], d_q[$];
   logic        if_act = 1'b0, d_act = 1'b0;
   logic [31:0] ref_mem [64];
   int          free_cyc = 0, run_m = 0;
   int          ce_exp = -100, if_ack_exp = -100, d_ack_exp = -100;
   logic        exp_we, d_exp_read = 1'b0;
   logic [31:0] exp_addr, exp_wdata, if_rdata_exp, d_rdata_exp;
   logic [3:0]  exp_sel;
   logic        log_en = 1'b0;
   logic [5:0]  ack_order = '0;
   int          n_logged = 0;

   task automatic drive_inputs();
      req_t r;
      if (if_act && cyc - 1 == if_ack_exp) if_act = 1'b0;
      if (d_act && cyc - 1 == d_ack_exp) d_act = 1'b0;
      if (!if_act && if_q.size() > 0) begin
         if (if_q[0].gap > 0) if_q[0].gap = if_q[0].gap - 1;
         else begin
            r = if_q.pop_front();
            if_addr = r.addr;
            if_act = 1'b1;
         end
      end
      if (!d_act && d_q.size() > 0) begin
         if (d_q[0].gap > 0) d_q[0].gap = d_q[0].gap - 1;
         else begin
            r = d_q.pop_front();
            d_we = r.we;
            d_addr = r.addr;
            d_sel = r.sel;
            d_wdata = r.wdata;
            d_act = 1'b1;
         end
      end
      if_req = if_act;
      d_req  = d_act;
   endtask

   task automatic model_step();
      logic mem_win;
      if (cyc >= free_cyc && (if_req || d_req)) begin
         mem_win = d_req && !(if_req && run_m == MAX_DATA_RUN);
         ce_exp = cyc + 1;
         if (mem_win) begin
            run_m = if_req ? ((run_m < MAX_DATA_RUN) ? run_m + 1 : run_m) : 0;
            exp_we = d_we;
            exp_addr = d_addr;
            exp_sel = d_sel;
            exp_wdata = d_wdata;
            if (d_we) begin
               ref_mem[d_addr[7:2]] = merge(ref_mem[d_addr[7:2]], d_wdata, d_sel);
               d_ack_exp = cyc + 2;
               d_exp_read = 1'b0;
            end else begin
               d_rdata_exp = ref_mem[d_addr[7:2]];
               d_ack_exp = cyc + 2 + RD_LATENCY;
               d_exp_read = 1'b1;
            end
            free_cyc = d_ack_exp + 1;
         end else begin
            run_m = 0;
            exp_we = 1'b0;
            exp_addr = if_addr;
            exp_sel = 4'hF;
            if_rdata_exp = ref_mem[if_addr[7:2]];
            if_ack_exp = cyc + 2 + RD_LATENCY;
            free_cyc = if_ack_exp + 1;
         end
      end
   endtask

   task automatic check_cycle();
      check("if_ack", 32'(if_ack), 32'(cyc == if_ack_exp));
      check("d_ack", 32'(d_ack), 32'(cyc == d_ack_exp));
      check("ram_ce", 32'(ram_ce), 32'(cyc == ce_exp));
      check("stallreq_if", 32'(stallreq_if), 32'(if_req && cyc != if_ack_exp));
      check("stallreq_mem", 32'(stallreq_mem), 32'(d_req && cyc != d_ack_exp));
      if (cyc == ce_exp) begin
         check("ram_we", 32'(ram_we), 32'(exp_we));
         check("ram_addr", ram_addr, exp_addr);
         check("ram_sel", 32'(ram_sel), 32'(exp_sel));
         if (exp_we) check("ram_wdata", ram_wdata, exp_wdata);
      end
      if (cyc == if_ack_exp) check("if_rdata", if_rdata, if_rdata_exp);
      if (cyc == d_ack_exp && d_exp_read) check("d_rdata", d_rdata, d_rdata_exp);
      if (log_en && n_logged < 6 && (if_ack || d_ack)) begin
         ack_order = {ack_order[4:0], d_ack};
         n_logged++;
      end
   endtask

   task automatic run_cycle();
      @(posedge clk);
      cyc++;
      #1;
      drive_inputs();
      model_step();
      @(negedge clk);
      check_cycle();
   endtask

   task automatic run_until_drained(input int limit);
      int n;
      n = 0;
      while ((if_q.size() > 0 || d_q.size() > 0 || if_act || d_act || cyc < free_cyc) && n < limit) begin
         run_cycle();
         n++;
      end
      check("drain_in_budget", 32'(n < limit), 32'(1));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ram_ce"}, 32'(ram_ce), 32'(0));
      check({tag, "_ram_we"}, 32'(ram_we), 32'(0));
      check({tag, "_ram_addr"}, ram_addr, 32'(0));
      check({tag, "_ram_sel"}, 32'(ram_sel), 32'(0));
      check({tag, "_ram_wdata"}, ram_wdata, 32'(0));
      check({tag, "_acks"}, 32'({if_ack, d_ack}), 32'(0));
      check({tag, "_if_rdata"}, if_rdata, 32'(0));
      check({tag, "_d_rdata"}, d_rdata, 32'(0));
   endtask

   initial begin
      req_t r;
      if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      if_addr = '0; d_addr = '0; d_sel = '0; d_wdata = '0;
      for (int i = 0; i < 64; i++) ref_mem[i] = seed_word(i);
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      ram_load = 1'b0;
      #1 check_reset_outputs("reset");
      @(negedge clk);
      rst = 1'b0;

      // Single IF read, then a partial MEM write and its read-back
      if_q.push_back('{gap: 0, we: 1'b0, addr: 32'h0000_0010, sel: 4'hF, wdata: 32'h0});
      run_until_drained(30);
      d_q.push_back('{gap: 0, we: 1'b1, addr: 32'h0000_0020, sel: 4'b0011, wdata: 32'hDEAD_BEEF});
      run_until_drained(30);
      d_q.push_back('{gap: 0, we: 1'b0, addr: 32'h0000_0020, sel: 4'hF, wdata: 32'h0});
      run_until_drained(30);

      // Both ports held busy from the same IDLE cycle: MEM run capped, then IF
      log_en = 1'b1;
      for (int i = 0; i < 2; i++) if_q.push_back('{gap: 0, we: 1'b0, addr: 32'(8 * i), sel: 4'hF, wdata: 32'h0});
      for (int i = 0; i < 6; i++) d_q.push_back('{gap: 0, we: 1'b1, addr: 32'(64 + 4 * i), sel: 4'hF, wdata: $urandom()});
      run_until_drained(200);
      log_en = 1'b0;
      check("starve_order", 32'(ack_order), 32'(6'b111101));

      // Random mixed traffic
      for (int i = 0; i < 40; i++) begin
         r.gap = $urandom_range(0, 4); r.we = 1'b0; r.sel = 4'hF; r.wdata = '0;
         r.addr = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
         if_q.push_back(r);
      end
      for (int i = 0; i < 60; i++) begin
         r.gap = $urandom_range(0, 4); r.we = 1'($urandom_range(0, 1));
         r.sel = 4'($urandom_range(1, 15)); r.wdata = $urandom();
         r.addr = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
         d_q.push_back(r);
      end
      run_until_drained(3000);

      // Asynchronous reset while a MEM read sits in WAIT
      d_q.push_back('{gap: 0, we: 1'b0, addr: 32'h0000_0044, sel: 4'hF, wdata: 32'h0});
      for (int i = 0; i < 20; i++) begin
         run_cycle();
         if (d_exp_read && cyc == ce_exp + 1) break;
      end
      #2 rst = 1'b1;
      #1 check_reset_outputs("rst_async");
      d_req = 1'b0; d_act = 1'b0;
      if_addr = 32'h0000_0030; if_req = 1'b1; if_act = 1'b1;
      run_m = 0; free_cyc = 0; ce_exp = -100; if_ack_exp = -100; d_ack_exp = -100;
      @(posedge clk);
      cyc++;
      #1 check_reset_outputs("rst_held");
      @(negedge clk);
      rst = 1'b0;
      model_step();
      check_cycle();
      run_until_drained(40);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/inst_data_mem_arbiter.md
Name: inst_data_mem_arbiter

Overview:
- Shares one single-port synchronous RAM between the instruction-fetch port (IF) and the load/store port (MEM) of the OpenMIPS pipeline inside openmips_min_spoc.
- Fixed priority to MEM, with an anti-starvation cap that guarantees IF forward progress.
- Serves one access at a time and raises per-port stall requests toward the pipeline ctrl unit while a port is waiting.

Parameters:
- RD_LATENCY, 1, cycles from the RAM sampling ram_ce=1 to ram_rdata being valid; legal range 1..15.
- MAX_DATA_RUN, 4, maximum consecutive MEM grants while if_req is pending; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high (`RstEnable = 1'b1`).
- if_req  in  1  IF access request, read-only; held with if_addr stable until if_ack.
- if_addr  in  32  IF byte address.
- if_ack  out  1  one-cycle completion pulse for IF.
- if_rdata  out  32  IF read data; valid with if_ack, held until the next if_ack.
- d_req  in  1  MEM access request; held with the other d_* inputs stable until d_ack.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  32  MEM byte address.
- d_sel  in  4  byte enables.
- d_wdata  in  32  write data.
- d_ack  out  1  one-cycle completion pulse for MEM.
- d_rdata  out  32  MEM read data; valid with d_ack for reads, held until the next MEM read ack.
- ram_ce  out  1  RAM access strobe, exactly one cycle per access.
- ram_we  out  1  RAM write enable.
- ram_addr  out  32  RAM address.
- ram_sel  out  4  RAM byte enables; 4'hF for IF accesses.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data.
- stallreq_if  out  1  combinational: if_req & ~if_ack.
- stallreq_mem  out  1  combinational: d_req & ~d_ack.

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE, run counter=0.
  - All registered outputs 0: ram_*, if_ack, d_ack, if_rdata, d_rdata.
  - Any in-flight access is abandoned and no ack is produced for it.
- States: IDLE, ACCESS, WAIT, DONE. The ram_* outputs and the acks are registered.
- IDLE:
  - No request: stay in IDLE.
  - Otherwise pick the winner. MEM wins if d_req && !(if_req && run==MAX_DATA_RUN); else IF wins.
  - Latch the winner's id, addr, we, sel and wdata, then go to ACCESS.
- ACCESS (one cycle): ram_ce=1 and ram_* carry the latched values. Next state is DONE for a write, WAIT for a read; the wait counter loads RD_LATENCY.
- WAIT:
  - Decrement the counter each cycle.
  - In the cycle the counter reaches its final value, the edge at the end of that cycle latches ram_rdata into the winner's rdata register. Next state is DONE.
  - The first WAIT cycle is RAM cycle 1 after sampling, so ram_rdata is captured exactly RD_LATENCY cycles after the ACCESS edge.
- DONE (one cycle): the winner's ack=1. Next state is always IDLE. Arbitration never takes place in DONE, because the acked port's req still refers to the served request during that cycle.
- Latency from req seen in IDLE at cycle t:
  - read: ack in cycle t+2+RD_LATENCY.
  - write: ack in cycle t+2.
- Run counter:
  - MEM grant while if_req=1: increment, saturating at MAX_DATA_RUN.
  - IF grant: clear.
  - MEM grant with if_req=0: clear.
- Requests asserted while the arbiter is busy are only considered at the next IDLE.
- Both reqs in the same IDLE cycle follow the rule above; the loser stays stalled.
- Requester contract: after ack, a port may drop req or present a new request. A new request is seen no earlier than the IDLE cycle that follows DONE.
- IF writes are impossible: ram_we=0 for IF grants.

Decomposition:
- Shared defines header:
  - RstEnable/RstDisable.
  - State encodings as `define constants (ARB_IDLE, ARB_ACCESS, ARB_WAIT, ARB_DONE, 2 bits).
  - Port id constants ArbIf=1'b0, ArbMem=1'b1.
- No sub-module required. The arbitration decision plus run counter may be split into inst_data_mem_arb_pick if reused for a future second bus.

Test Plan:
- Single IF read: RD_LATENCY=1, if_req=1 at t with if_addr=32'h0000_0010, RAM model returns 32'h3401_1100. Required:
  - ram_ce=1 at t+1 with ram_sel=4'hF and ram_we=0.
  - if_ack=1 at t+3 only, with if_rdata=32'h3401_1100.
  - stallreq_if=1 during t..t+2.
- MEM write: d_we=1, d_addr=32'h20, d_sel=4'b0011, d_wdata=32'hDEAD_BEEF. Required:
  - ram_ce=ram_we=1 at t+1 with the same sel/wdata.
  - d_ack at t+2.
  - if_ack stays 0.
- Simultaneous requests: if_req and d_req both asserted in IDLE, run=0. Required: MEM served first. IF is granted at the next IDLE and acks after MEM.
- Starvation cap: MAX_DATA_RUN=4, d_req and if_req held continuously. Required: grant sequence MEM,MEM,MEM,MEM,IF,MEM…, with the run counter cleared after the IF grant.
- Latency sweep: RD_LATENCY=3, MEM read. Required: d_ack exactly 5 cycles after the IDLE request cycle, with d_rdata equal to the model data.
- Async reset in WAIT: assert rst mid-read, asynchronously between edges. Required:
  - All outputs 0 immediately.
  - No ack for the abandoned access.
  - After release, a pending if_req is served normally from IDLE.
